pattern_trigger_sequencer: RTL

- Multi-stage controller for the USB pattern matcher: holds up to pSTAGES pattern/mask/length sets and loads them one at a time into a single matcher instance.
- Arms the matcher, waits for its match pulse, then re-arms it with the next stage's pattern.
- Asserts the final trigger only when all configured stages match in order, each stage within its timeout window.
- Sits between the register block and pattern matcher; O_trigger feeds the trigger block.

---
 rtl/pattern_trigger_sequencer_if.sv | 21 ++
 rtl/pattern_trigger_sequencer.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/pattern_trigger_sequencer_if.sv
// Sequencer <-> pattern matcher link: stage pattern/mask/length out, one-cycle match pulse back.
interface pattern_trigger_sequencer_if #(
  parameter int pPATTERN_BYTES = 8
);
  logic [pPATTERN_BYTES*8-1:0] O_pattern;
  logic [pPATTERN_BYTES*8-1:0] O_mask;
  logic [7:0]                  O_pattern_bytes;
  logic [15:0]                 O_num_triggers;
  logic                        O_match_arm;
  logic                        I_match_trigger;

  modport master (
    output O_pattern, O_mask, O_pattern_bytes, O_num_triggers, O_match_arm,
    input  I_match_trigger
  );

  modport slave (
    input  O_pattern, O_mask, O_pattern_bytes, O_num_triggers, O_match_arm,
    output I_match_trigger
  );
endinterface

// File: rtl/pattern_trigger_sequencer.sv
// Multi-stage trigger sequencer: loads each stage's pattern into one matcher, re-arms it per stage,
// and fires O_trigger only when every configured stage matches in order inside its timeout window.
module pattern_trigger_sequencer #(
  parameter int pPATTERN_BYTES = 8,
  parameter int pSTAGES        = 4,
  parameter int pREARM_GAP     = 4
) (
  input  logic                                fe_clk,
  input  logic                                reset_n,
  input  logic                                I_arm,
  input  logic                                I_abort,
  input  logic [3:0]                          I_num_stages,
  input  logic [pSTAGES*pPATTERN_BYTES*8-1:0] I_patterns,
  input  logic [pSTAGES*pPATTERN_BYTES*8-1:0] I_masks,
  input  logic [pSTAGES*8-1:0]                I_pattern_bytes,
  input  logic [pSTAGES*16-1:0]               I_timeouts,
  pattern_trigger_sequencer_if.master         mif,
  output logic                                O_trigger,
  output logic                                O_timeout_pulse,
  output logic                                O_done_pulse,
  output logic                                O_busy,
  output logic [2:0]                          O_stage
);
  localparam int PW = pPATTERN_BYTES * 8;
  localparam int GW = $clog2(pREARM_GAP + 1);

  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_ARMED, ST_DONE} state_t;

  state_t         state_reg;
  logic           arm_d_reg;
  logic [2:0]     stage_reg;
  logic [2:0]     last_stage_reg;
  logic [GW-1:0]  gap_reg;
  logic [15:0]    timer_reg;
  logic [15:0]    window_reg;
  logic [PW-1:0]  pattern_reg;
  logic [PW-1:0]  mask_reg;
  logic [7:0]     bytes_reg;
  logic           match_arm_reg;
  logic           trigger_reg;
  logic           timeout_reg;
  logic           done_reg;
  logic           busy_reg;

  // Slot arrays are always 8 deep so a 3-bit stage index never runs off the end.
  logic [PW-1:0]  pattern_slot [8];
  logic [PW-1:0]  mask_slot    [8];
  logic [7:0]     bytes_slot   [8];
  logic [15:0]    timeout_slot [8];

  for (genvar gi = 0; gi < 8; gi++) begin : g_slot
    if (gi < pSTAGES) begin : g_used
      assign pattern_slot[gi] = I_patterns[gi*PW +: PW];
      assign mask_slot[gi]    = I_masks[gi*PW +: PW];
      assign bytes_slot[gi]   = I_pattern_bytes[gi*8 +: 8];
      assign timeout_slot[gi] = I_timeouts[gi*16 +: 16];
    end else begin : g_unused
      assign pattern_slot[gi] = '0;
      assign mask_slot[gi]    = '0;
      assign bytes_slot[gi]   = '0;
      assign timeout_slot[gi] = '0;
    end
  end

  logic [3:0] num_clamped;
  always_comb begin
    num_clamped = I_num_stages;
    if (I_num_stages == 4'd0)
      num_clamped = 4'd1;
    else if (I_num_stages > 4'(pSTAGES))
      num_clamped = 4'(pSTAGES);
  end

  logic       arm_rise;
  logic       abort_any;
  logic       is_last;
  logic       timeout_hit;
  logic [2:0] load_stage;

  assign arm_rise    = I_arm && !arm_d_reg;
  assign abort_any   = I_abort || !I_arm;
  assign is_last     = (stage_reg == last_stage_reg);
  // The window is counted from the previous stage's match, so it includes the re-arm gap.
  assign timeout_hit = (stage_reg != 3'd0) && (window_reg != 16'd0) && (timer_reg == window_reg);
  assign load_stage  = (state_reg == ST_ARMED && mif.I_match_trigger && !is_last) ?
                       stage_reg + 3'd1 : 3'd0;

  always_ff @(posedge fe_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg      <= ST_IDLE;
      arm_d_reg      <= 1'b0;
      stage_reg      <= 3'd0;
      last_stage_reg <= 3'd0;
      gap_reg        <= '0;
      timer_reg      <= 16'd0;
      window_reg     <= 16'd0;
      pattern_reg    <= '0;
      mask_reg       <= '0;
      bytes_reg      <= 8'd0;
      match_arm_reg  <= 1'b0;
      trigger_reg    <= 1'b0;
      timeout_reg    <= 1'b0;
      done_reg       <= 1'b0;
      busy_reg       <= 1'b0;
    end else begin
      arm_d_reg   <= I_arm;
      trigger_reg <= 1'b0;
      timeout_reg <= 1'b0;
      done_reg    <= 1'b0;
      if ((state_reg == ST_LOAD || state_reg == ST_ARMED) && timer_reg != 16'hFFFF)
        timer_reg <= timer_reg + 16'd1;

      case (state_reg)
        ST_IDLE: begin
          timer_reg <= 16'd0;
          if (arm_rise && !I_abort) begin
            state_reg      <= ST_LOAD;
            stage_reg      <= 3'd0;
            last_stage_reg <= 3'(num_clamped - 4'd1);
            gap_reg        <= '0;
            busy_reg       <= 1'b1;
            pattern_reg    <= pattern_slot[load_stage];
            mask_reg       <= mask_slot[load_stage];
            bytes_reg      <= bytes_slot[load_stage];
            window_reg     <= timeout_slot[load_stage];
          end
        end

        ST_LOAD: begin
          if (abort_any) begin
            state_reg     <= ST_IDLE;
            stage_reg     <= 3'd0;
            match_arm_reg <= 1'b0;
            busy_reg      <= 1'b0;
            timer_reg     <= 16'd0;
          end else if (gap_reg == GW'(pREARM_GAP - 1)) begin
            state_reg     <= ST_ARMED;
            match_arm_reg <= 1'b1;
          end else begin
            gap_reg <= gap_reg + 1'b1;
          end
        end

        ST_ARMED: begin
          if (abort_any) begin
            state_reg     <= ST_IDLE;
            stage_reg     <= 3'd0;
            match_arm_reg <= 1'b0;
            busy_reg      <= 1'b0;
            timer_reg     <= 16'd0;
          end else if (mif.I_match_trigger || timeout_hit) begin
            // A match in the same cycle as the timeout takes precedence.
            timer_reg     <= 16'd0;
            match_arm_reg <= 1'b0;
            if (mif.I_match_trigger && is_last) begin
              state_reg   <= ST_DONE;
              trigger_reg <= 1'b1;
              done_reg    <= 1'b1;
              busy_reg    <= 1'b0;
            end else begin
              state_reg   <= ST_LOAD;
              stage_reg   <= load_stage;
              gap_reg     <= '0;
              timeout_reg <= !mif.I_match_trigger;
              pattern_reg <= pattern_slot[load_stage];
              mask_reg    <= mask_slot[load_stage];
              bytes_reg   <= bytes_slot[load_stage];
              window_reg  <= timeout_slot[load_stage];
            end
          end
        end

        ST_DONE: begin
          if (abort_any) begin
            state_reg <= ST_IDLE;
            stage_reg <= 3'd0;
          end
        end

        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign mif.O_pattern       = pattern_reg;
  assign mif.O_mask          = mask_reg;
  assign mif.O_pattern_bytes = bytes_reg;
  assign mif.O_num_triggers  = 16'd1;
  assign mif.O_match_arm     = match_arm_reg;
  assign O_trigger           = trigger_reg;
  assign O_timeout_pulse     = timeout_reg;
  assign O_done_pulse        = done_reg;
  assign O_busy              = busy_reg;
  assign O_stage             = stage_reg;
endmodule
